inst_fetch_unit: RTL

Instruction fetch sequencer: the producing end of the 32-bit instruction word that the control unit decodes. It owns the program counter, applies the control unit's PC_SEL/PC_MUX commands (hold, increment, PC-relative branch, register branch), fetches the next word from instruction memory over a req/ack handshake and presents it with a valid flag. It sits between instruction memory and the control unit, replacing the free-running PC path in the datapath.

---
 rtl/inst_fetch_unit_pkg.sv | 25 ++
 rtl/inst_fetch_unit_next_pc.sv | 41 ++++
 rtl/inst_fetch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// ============================================================================
// inst_fetch_unit_pkg : PC command encodings, fetch states, word width
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_fetch_unit_pkg;

  localparam int INST_W = 32;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_next_pc.sv
// ============================================================================
// next_pc_calc : next program counter target and misalignment detect
// Revision 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic              pc_mux,
  input  logic [63:0]       k,
  input  logic [63:0]       a_bus,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] word_off;

  // Word offsets become byte offsets; bits shifted past the top are dropped.
  assign word_off = pc_mux ? {k[ADDR_W-3:0], 2'b00} : {a_bus[ADDR_W-3:0], 2'b00};

  always_comb begin
    target = pc;
    case (pc_sel)
      PC_HOLD: target = pc;
      PC_INC:  target = pc + ADDR_W'(4);
      PC_REL:  target = pc + word_off;
      PC_REG:  target = a_bus[ADDR_W-1:0];
      default: target = pc;
    endcase
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit : PC owner, req/ack instruction fetch, command sequencing
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        pc_sel,
  input  logic              pc_mux,
  input  logic [63:0]       k,
  input  logic [63:0]       a_bus,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] target;
  logic              misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc         (pc),
    .pc_sel     (pc_sel),
    .pc_mux     (pc_mux),
    .k          (k),
    .a_bus      (a_bus),
    .target     (target),
    .misaligned (misaligned)
  );

  assign mem_addr = pc;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      cmd_ready  <= 1'b0;
      mem_req    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state   <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (mem_ack) begin
            inst       <= mem_rdata;
            state      <= ST_HOLD;
            mem_req    <= 1'b0;
            inst_valid <= 1'b1;
            cmd_ready  <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A hold command keeps the current word for re-decode, no refetch.
          if (cmd_valid && (pc_sel != PC_HOLD)) begin
            pc         <= target;
            inst_valid <= 1'b0;
            cmd_ready  <= 1'b0;
            if (misaligned) begin
              fault <= 1'b1;
              state <= ST_FAULT;
            end else begin
              state   <= ST_FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
